// File: rtl/test_event_pkg.sv
// Shared types and constant helpers for the RP BFM test status controller.
package test_event_pkg;

   typedef enum logic [1:0] {
      ERR   = 2'd0,
      APASS = 2'd1,
      AFAIL = 2'd2,
      KICK  = 2'd3
   } t_evt_type;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      TIMEOUT = 2'd2,
      DONE    = 2'd3
   } t_test_state;

   // Watchdog reload value: cycles in delay_ns, rounded up, minus one.
   function automatic logic [63:0] calc_max_dly(input logic [63:0] delay_ns,
                                                input logic [63:0] clk_hz);
      logic [63:0] d;
      d = clk_hz * delay_ns / 64'd1_000_000_000;
      if ((clk_hz != 64'd0) && ((d * 64'd1_000_000_000 / clk_hz) < delay_ns))
         d = d + 64'd1;
      return (d > 64'd0) ? d - 64'd1 : 64'd0;
   endfunction

   // Saturating add for a w-bit counter carried in a 64-bit container.
   function automatic logic [63:0] sat_add(input logic [63:0] cnt,
                                           input logic [1:0]  inc,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, cnt} + {63'd0, inc};
      lim = (65'd1 << w) - 65'd1;
      return (sum > lim) ? lim[63:0] : sum[63:0];
   endfunction

endpackage

// File: rtl/test_event_rr_arb.sv
// Round-robin event arbiter: one-hot grant plus granted index, pointer advances past each grant.
module test_event_rr_arb
   import test_event_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_valid_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               grant_vld_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
         if (!grant_vld_o && req_valid_i[cand]) begin
            grant_vld_o   = 1'b1;
            grant_idx_o   = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_vld_o)
         ptr_d = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/test_event_arb.sv
// Test status controller: RR event arbitration, saturating counters, watchdog and test FSM.
// Optional event logging is compiled in with TEST_EVENT_LOG_EN.
module test_event_arb
  import test_event_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TIMEOUT_NS  = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 done,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_type,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     assert_count,
  output logic [CNT_W-1:0]     assert_err_count,
  output logic [1:0]           state,
  output logic                 timeout,
  output logic                 test_pass
);

  localparam logic [63:0] MAX_DLY = calc_max_dly(64'(TIMEOUT_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned WD_W    = (MAX_DLY >= 64'd1) ? $clog2(MAX_DLY + 64'd1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_DLY);
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  t_test_state      state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] err_q, err_d, ass_q, ass_d, aerr_q, aerr_d;
  logic [1:0]       err_inc, ass_inc, aerr_inc;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  t_evt_type        evt;

  test_event_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .grant_o     (req_ready),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign evt = t_evt_type'(req_type[{grant_idx, 1'b0} +: 2]);

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    err_inc  = 2'd0;
    ass_inc  = 2'd0;
    aerr_inc = 2'd0;
    if (grant_vld) begin
      case (evt)
        ERR:     err_inc = 2'd1;
        APASS:   ass_inc = 2'd1;
        AFAIL: begin
          ass_inc  = 2'd1;
          aerr_inc = 2'd1;
        end
        default: ;
      endcase
    end
    // done outranks an accepted event, which outranks watchdog expiry
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          wd_d    = WD_MAX;
        end
      end
      RUN: begin
        if (done)
          state_d = DONE;
        else if (grant_vld)
          wd_d = WD_MAX;
        else if (wd_q == '0) begin
          state_d = TIMEOUT;
          err_inc = err_inc + 2'd1;
        end else
          wd_d = wd_q - 1'b1;
      end
      default: ;
    endcase
    err_d  = CNT_W'(sat_add(64'(err_q),  err_inc,  CNT_W));
    ass_d  = CNT_W'(sat_add(64'(ass_q),  ass_inc,  CNT_W));
    aerr_d = CNT_W'(sat_add(64'(aerr_q), aerr_inc, CNT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wd_q    <= WD_MAX;
      err_q   <= '0;
      ass_q   <= '0;
      aerr_q  <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      ass_q   <= ass_d;
      aerr_q  <= aerr_d;
    end
  end

  assign err_count        = err_q;
  assign assert_count     = ass_q;
  assign assert_err_count = aerr_q;
  assign state            = state_q;
  assign timeout          = (state_q == TIMEOUT);
  assign test_pass        = (state_q == DONE) && (err_q == '0) && (aerr_q == '0);

`ifdef TEST_EVENT_LOG_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (grant_vld)
        $display("[%0t] req%0d %s err=%0d aerr=%0d",
                 $time, grant_idx, evt.name(), err_d, aerr_d);
      if ((state_q != TIMEOUT) && (state_d == TIMEOUT))
        $display("TIMEOUT");
      if ((state_q != DONE) && (state_d == DONE))
        $display("%s", ((err_d == '0) && (aerr_d == '0)) ? "PASS" : "FAIL");
    end
  end
`endif

endmodule

// File: tb/tb_test_event_arb.sv
// Directed self-checking bench for test_event_arb (CNT_W=4, 100 MHz, 105 ns watchdog -> MAX_DLY=10).
module tb_test_event_arb;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       done = 1'b0;
   logic [3:0] req_valid = '0;
   logic [7:0] req_type = '0;
   logic [3:0] req_ready;
   logic [3:0] err_count, assert_count, assert_err_count;
   logic [1:0] state;
   logic       timeout, test_pass;

   int checks = 0;
   int passes = 0;

   test_event_arb #(
      .NUM_REQ    (4),
      .CNT_W      (4),
      .CLK_FREQ_HZ(100000000),
      .TIMEOUT_NS (105)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .done            (done),
      .req_valid       (req_valid),
      .req_type        (req_type),
      .req_ready       (req_ready),
      .err_count       (err_count),
      .assert_count    (assert_count),
      .assert_err_count(assert_err_count),
      .state           (state),
      .timeout         (timeout),
      .test_pass       (test_pass)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL tb_time_limit: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      start = 0; done = 0; req_valid = '0; req_type = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick; tick;
      rst_n = 1'b1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (err_count !== 4'd0) $display("FAIL reset_err: got %0d expected 0", err_count); else passes++;
      checks++; if (assert_count !== 4'd0) $display("FAIL reset_assert: got %0d expected 0", assert_count); else passes++;
      checks++; if (assert_err_count !== 4'd0) $display("FAIL reset_aerr: got %0d expected 0", assert_err_count); else passes++;
      checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else passes++;
      checks++; if (test_pass !== 1'b0) $display("FAIL reset_pass: got %b expected 0", test_pass); else passes++;
      checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else passes++;
      req_valid = 4'b0001; req_type = 8'h01;
      #1;
      checks++; if (req_ready !== 4'b0001) $display("FAIL reset_ready_same_cycle: got %b expected 0001", req_ready); else passes++;
      tick;
      req_valid = '0;
      checks++; if (assert_count !== 4'd1) $display("FAIL idle_event_assert: got %0d expected 1", assert_count); else passes++;
      done = 1'b1; tick; done = 1'b0;
      checks++; if (state !== 2'd0) $display("FAIL done_in_idle_ignored: got %0d expected 0", state); else passes++;
   endtask

   task automatic test_contention;
      logic [3:0] exp;
      do_reset;
      req_valid = 4'b1111; req_type = 8'h55;
      for (int i = 0; i < 8; i++) begin
         exp = 4'b0001 << (i % 4);
         #1;
         checks++; if (req_ready !== exp) $display("FAIL contention_grant%0d: got %b expected %b", i, req_ready, exp); else passes++;
         tick;
      end
      req_valid = '0;
      checks++; if (assert_count !== 4'd8) $display("FAIL contention_assert: got %0d expected 8", assert_count); else passes++;
      checks++; if (err_count !== 4'd0) $display("FAIL contention_err: got %0d expected 0", err_count); else passes++;
   endtask

   task automatic test_mixed;
      do_reset;
      pulse_start;
      checks++; if (state !== 2'd1) $display("FAIL mixed_run: got %0d expected 1", state); else passes++;
      req_valid = 4'b0010; req_type = 8'h00;
      #1;
      checks++; if (req_ready !== 4'b0010) $display("FAIL mixed_grant_req1: got %b expected 0010", req_ready); else passes++;
      tick;
      req_valid = 4'b0100; req_type = 8'h20;
      #1;
      checks++; if (req_ready !== 4'b0100) $display("FAIL mixed_grant_req2: got %b expected 0100", req_ready); else passes++;
      tick;
      req_valid = '0;
      done = 1'b1; tick; done = 1'b0;
      checks++; if (err_count !== 4'd1) $display("FAIL mixed_err: got %0d expected 1", err_count); else passes++;
      checks++; if (assert_count !== 4'd1) $display("FAIL mixed_assert: got %0d expected 1", assert_count); else passes++;
      checks++; if (assert_err_count !== 4'd1) $display("FAIL mixed_aerr: got %0d expected 1", assert_err_count); else passes++;
      checks++; if (state !== 2'd3) $display("FAIL mixed_state: got %0d expected 3", state); else passes++;
      checks++; if (test_pass !== 1'b0) $display("FAIL mixed_pass: got %b expected 0", test_pass); else passes++;
      pulse_start;
      checks++; if (state !== 2'd3) $display("FAIL start_in_done_ignored: got %0d expected 3", state); else passes++;
   endtask

   task automatic test_watchdog;
      do_reset;
      pulse_start;
      repeat (10) tick;
      checks++; if (state !== 2'd1) $display("FAIL wd_before_expiry: got %0d expected 1", state); else passes++;
      tick;
      checks++; if (state !== 2'd2) $display("FAIL wd_expired_state: got %0d expected 2", state); else passes++;
      checks++; if (timeout !== 1'b1) $display("FAIL wd_timeout_flag: got %b expected 1", timeout); else passes++;
      checks++; if (err_count !== 4'd1) $display("FAIL wd_err: got %0d expected 1", err_count); else passes++;
      pulse_start;
      checks++; if (state !== 2'd2) $display("FAIL timeout_terminal: got %0d expected 2", state); else passes++;
   endtask

   task automatic test_kick;
      do_reset;
      pulse_start;
      repeat (9) tick;
      req_valid = 4'b1000; req_type = 8'hC0;
      tick;
      req_valid = '0;
      repeat (10) tick;
      checks++; if (state !== 2'd1) $display("FAIL kick_deferred: got %0d expected 1", state); else passes++;
      tick;
      checks++; if (state !== 2'd2) $display("FAIL kick_then_expiry: got %0d expected 2", state); else passes++;
      checks++; if (err_count !== 4'd1) $display("FAIL kick_err: got %0d expected 1", err_count); else passes++;
   endtask

   task automatic test_saturation;
      do_reset;
      req_valid = 4'b0001; req_type = 8'h00;
      repeat (14) tick;
      req_valid = '0;
      checks++; if (err_count !== 4'd14) $display("FAIL sat_preload: got %0d expected 14", err_count); else passes++;
      pulse_start;
      repeat (10) tick;
      req_valid = 4'b0001; req_type = 8'h00;
      tick;
      req_valid = '0;
      checks++; if (err_count !== 4'd15) $display("FAIL sat_event_on_expiry_err: got %0d expected 15", err_count); else passes++;
      checks++; if (state !== 2'd1) $display("FAIL sat_event_wins_state: got %0d expected 1", state); else passes++;
      for (int n = 0; n < 20 && state != 2'd2; n++) tick;
      checks++; if (state !== 2'd2) $display("FAIL sat_timeout_reached: got %0d expected 2", state); else passes++;
      checks++; if (err_count !== 4'd15) $display("FAIL sat_no_wrap: got %0d expected 15", err_count); else passes++;
   endtask

   task automatic test_reset_mid_run;
      do_reset;
      pulse_start;
      req_valid = 4'b0010; req_type = 8'h00;
      repeat (3) tick;
      req_valid = '0;
      checks++; if (err_count !== 4'd3) $display("FAIL midrst_preload: got %0d expected 3", err_count); else passes++;
      rst_n = 1'b0;
      #1;
      checks++; if (err_count !== 4'd0) $display("FAIL midrst_err_async: got %0d expected 0", err_count); else passes++;
      checks++; if (state !== 2'd0) $display("FAIL midrst_state_async: got %0d expected 0", state); else passes++;
      tick;
      rst_n = 1'b1;
      pulse_start;
      checks++; if (state !== 2'd1) $display("FAIL midrst_restart: got %0d expected 1", state); else passes++;
      repeat (11) tick;
      checks++; if (state !== 2'd2) $display("FAIL midrst_restart_timeout: got %0d expected 2", state); else passes++;
      checks++; if (err_count !== 4'd1) $display("FAIL midrst_restart_err: got %0d expected 1", err_count); else passes++;
   endtask

   initial begin
      test_reset;
      test_contention;
      test_mixed;
      test_watchdog;
      test_kick;
      test_saturation;
      test_reset_mid_run;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
